// File: rtl/keypad_pkg.sv
// keypad_pkg: shared constants, key-code layout and small helpers for the
// 4x4 keypad scanner.
//   COL_RESET   : column strobe pattern after reset (column 0 driven low)
//   ST_*        : scanner FSM state encodings
//   key_code_t  : {row_idx, col_idx} layout of KeyCode
//   col_index() : active-low one-hot column strobe -> column index
//   row_prio()  : active-low row vector -> index of lowest low row
package keypad_pkg;

   localparam int NUM_ROWS   = 4;
   localparam int NUM_COLS   = 4;
   localparam int KEY_CODE_W = 4;

   localparam logic [NUM_COLS-1:0] COL_RESET = 4'b1110;

   localparam logic [1:0] ST_SCAN     = 2'd0;
   localparam logic [1:0] ST_DEBOUNCE = 2'd1;
   localparam logic [1:0] ST_HOLD     = 2'd2;

   typedef struct packed {
      logic [1:0] row;
      logic [1:0] col;
   } key_code_t;

   function automatic logic [1:0] col_index(input logic [NUM_COLS-1:0] col);
      case (col)
         4'b1101: return 2'd1;
         4'b1011: return 2'd2;
         4'b0111: return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

   // Lowest-index low row wins when several rows are pressed at once.
   function automatic logic [1:0] row_prio(input logic [NUM_ROWS-1:0] row);
      if (!row[0])      return 2'd0;
      else if (!row[1]) return 2'd1;
      else if (!row[2]) return 2'd2;
      else              return 2'd3;
   endfunction

endpackage

// File: rtl/keypad_if.sv
// keypad_if: key-code handshake between the scanner and its consumer.
//   KeyCode  : {row_idx, col_idx} of the debounced key (scanner -> consumer)
//   KeyValid : code available, held until accepted    (scanner -> consumer)
//   KeyReady : consumer accepts when KeyValid & KeyReady (consumer -> scanner)
//   Overrun  : one-cycle pulse, a new key was dropped  (scanner -> consumer)
// master = scanner side, slave = consumer side.
interface keypad_if
   import keypad_pkg::*;
();
   logic [KEY_CODE_W-1:0] KeyCode;
   logic                  KeyValid;
   logic                  KeyReady;
   logic                  Overrun;

   modport master (output KeyCode, output KeyValid, output Overrun, input KeyReady);
   modport slave  (input KeyCode, input KeyValid, input Overrun, output KeyReady);
endinterface

// File: rtl/keypad_debounce.sv
// keypad_debounce: LEN-deep run detector on a per-tick match bit.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   tick_i        : sample enable; history only moves on a tick
//   restart_i     : this tick's sample starts a fresh run (history dropped)
//   match_i       : sample value for this tick
//   stable_hi_o   : this tick completes LEN consecutive 1 samples
//   stable_lo_o   : this tick completes LEN consecutive 0 samples
// Only LEN-1 samples are stored; the current sample comes straight from
// match_i so the decision lands on the completing tick itself.
module keypad_debounce #(
   parameter int LEN = 4
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic tick_i,
   input  logic restart_i,
   input  logic match_i,
   output logic stable_hi_o,
   output logic stable_lo_o
);
   logic [LEN-2:0] hist_q, hist_d;
   logic [LEN-1:0] shift_w;

   assign shift_w = {hist_q, match_i};

   always_comb begin
      hist_d = hist_q;
      if (tick_i) begin
         if (restart_i) begin
            hist_d    = '0;
            hist_d[0] = match_i;
         end else begin
            hist_d = shift_w[LEN-2:0];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) hist_q <= '0;
      else         hist_q <= hist_d;
   end

   assign stable_hi_o = tick_i & ~restart_i & match_i  & (&hist_q);
   assign stable_lo_o = tick_i & ~restart_i & ~match_i & ~(|hist_q);
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad driver. Strobes columns active-low one
// at a time, samples the synchronised rows once per column dwell, debounces
// press and release, and offers the key code on a valid/ready handshake.
//   Clock   : system clock
//   Reset_n : asynchronous active-low reset
//   Row     : keypad rows, active-low, asynchronous to Clock
//   Col     : column strobes, active-low one-hot
//   kp      : keypad_if.master (KeyCode, KeyValid, Overrun out; KeyReady in)
// Optional build macro KEYPAD_REPEAT_EN: auto-repeat of a held key after
// REPEAT_DELAY hold ticks, then every REPEAT_RATE ticks.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SAMPLE_DIV   = 16,
   parameter int DEBOUNCE_LEN = 4,
   parameter int REPEAT_DELAY = 32,
   parameter int REPEAT_RATE  = 8
) (
   input  logic                Clock,
   input  logic                Reset_n,
   input  logic [NUM_ROWS-1:0] Row,
   output logic [NUM_COLS-1:0] Col,
   keypad_if.master            kp
);
   localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

   logic [NUM_ROWS-1:0]   row_s1_q, row_s2_q;
   logic [DIV_W-1:0]      div_q, div_d;
   logic [NUM_COLS-1:0]   col_q, col_d;
   logic [1:0]            state_q, state_d;
   logic [1:0]            row_idx_q, row_idx_d;
   logic [KEY_CODE_W-1:0] code_q, code_d;
   logic                  kv_q, kv_d;
   logic                  ovr_q, ovr_d;

   logic       tick, hit, latched_low;
   logic [1:0] hit_row;
   logic       db_restart, db_match, stable_hi, stable_lo;
   logic       emit, rpt_emit, emit_any;
   key_code_t  new_code;

   // Rows idle high; synchroniser resets to the released pattern.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         row_s1_q <= '1;
         row_s2_q <= '1;
      end else begin
         row_s1_q <= Row;
         row_s2_q <= row_s1_q;
      end
   end

   assign tick        = (div_q == DIV_W'(SAMPLE_DIV - 1));
   assign div_d       = tick ? '0 : div_q + DIV_W'(1);
   assign hit         = ~(&row_s2_q);
   assign hit_row     = row_prio(row_s2_q);
   assign latched_low = ~row_s2_q[row_idx_q];

   keypad_debounce #(.LEN(DEBOUNCE_LEN)) u_db (
      .clk_i       (Clock),
      .rst_ni      (Reset_n),
      .tick_i      (tick),
      .restart_i   (db_restart),
      .match_i     (db_match),
      .stable_hi_o (stable_hi),
      .stable_lo_o (stable_lo)
   );

   // Press detection counts matching samples (stable_hi); release detection
   // in HOLD counts samples where the key is not low (stable_lo), so a single
   // debounce instance serves both.
   always_comb begin
      state_d    = state_q;
      col_d      = col_q;
      row_idx_d  = row_idx_q;
      db_restart = 1'b0;
      db_match   = 1'b0;
      emit       = 1'b0;
      case (state_q)
         ST_SCAN: begin
            db_restart = 1'b1;
            db_match   = hit;
            if (tick) begin
               if (hit) begin
                  row_idx_d = hit_row;
                  state_d   = ST_DEBOUNCE;
               end else begin
                  col_d = {col_q[NUM_COLS-2:0], col_q[NUM_COLS-1]};
               end
            end
         end
         ST_DEBOUNCE: begin
            // A lower row appearing changes the priority winner: treat as lost.
            db_match = hit && (hit_row == row_idx_q);
            if (tick) begin
               if (!db_match) begin
                  state_d = ST_SCAN;
                  col_d   = {col_q[NUM_COLS-2:0], col_q[NUM_COLS-1]};
               end else if (stable_hi) begin
                  emit    = 1'b1;
                  state_d = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            db_match = latched_low;
            if (stable_lo) begin
               state_d = ST_SCAN;
               col_d   = {col_q[NUM_COLS-2:0], col_q[NUM_COLS-1]};
            end
         end
         default: begin
            state_d = ST_SCAN;
            col_d   = COL_RESET;
         end
      endcase
   end

`ifdef KEYPAD_REPEAT_EN
   localparam int RPT_W = $clog2(REPEAT_DELAY + 1);
   logic [RPT_W-1:0] rpt_q, rpt_d;

   // Counts hold ticks with the key low; after each repeat it restarts at
   // DELAY-RATE so later repeats come every RATE ticks. Never exceeds DELAY.
   always_comb begin
      rpt_d    = rpt_q;
      rpt_emit = 1'b0;
      if (state_q != ST_HOLD) begin
         rpt_d = '0;
      end else if (tick) begin
         if (!latched_low) begin
            rpt_d = '0;
         end else if (rpt_q == RPT_W'(REPEAT_DELAY - 1)) begin
            rpt_d    = RPT_W'(REPEAT_DELAY - REPEAT_RATE);
            rpt_emit = 1'b1;
         end else begin
            rpt_d = rpt_q + RPT_W'(1);
         end
      end
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) rpt_q <= '0;
      else          rpt_q <= rpt_d;
   end
`else
   assign rpt_emit = 1'b0;
`endif

   assign emit_any     = emit | rpt_emit;
   assign new_code.row = row_idx_q;
   assign new_code.col = col_index(col_q);

   always_comb begin
      kv_d   = kv_q;
      code_d = code_q;
      ovr_d  = 1'b0;
      if (emit_any) begin
         if (!kv_q || kp.KeyReady) begin
            kv_d   = 1'b1;
            code_d = new_code;
         end else begin
            ovr_d = 1'b1;  // pending code wins, the new key is dropped
         end
      end else if (kv_q && kp.KeyReady) begin
         kv_d = 1'b0;
      end
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         div_q     <= '0;
         col_q     <= COL_RESET;
         state_q   <= ST_SCAN;
         row_idx_q <= '0;
         code_q    <= '0;
         kv_q      <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         div_q     <= div_d;
         col_q     <= col_d;
         state_q   <= state_d;
         row_idx_q <= row_idx_d;
         code_q    <= code_d;
         kv_q      <= kv_d;
         ovr_q     <= ovr_d;
      end
   end

   assign Col         = col_q;
   assign kp.KeyCode  = code_q;
   assign kp.KeyValid = kv_q;
   assign kp.Overrun  = ovr_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed vectors for keypad_scanner (SAMPLE_DIV=16,
// DEBOUNCE_LEN=4). Time is tracked in sample ticks counted from reset
// release; each tick is 16 clocks and outputs are sampled 1 time unit after
// the clock edge.
module tb_keypad_scanner;
   localparam int SD = 16;

   logic       Clock   = 1'b0;
   logic       Reset_n = 1'b0;
   logic [3:0] Row     = 4'hF;
   logic [3:0] Col;

   keypad_if kp_if ();

   keypad_scanner #(
      .SAMPLE_DIV  (SD),
      .DEBOUNCE_LEN(4),
      .REPEAT_DELAY(32),
      .REPEAT_RATE (8)
   ) dut (
      .Clock  (Clock),
      .Reset_n(Reset_n),
      .Row    (Row),
      .Col    (Col),
      .kp     (kp_if)
   );

   always #5 Clock = ~Clock;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic [3:0] row;
      logic       rdy;
      int         cyc;
      logic [3:0] col;
      logic       kv;
      logic [3:0] code;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input logic [3:0] row, input logic rdy, input int cyc,
                               input logic [3:0] col, input logic kv, input logic [3:0] code);
      vec_t v;
      v.row = row; v.rdy = rdy; v.cyc = cyc; v.col = col; v.kv = kv; v.code = code;
      tbl.push_back(v);
   endfunction

   task automatic adv(input int n);
      repeat (n) @(posedge Clock);
      #1;
   endtask

   // Leaves the bench 1 unit after a posedge with reset released, so the
   // next 16 edges complete tick 1.
   task automatic do_reset();
      Reset_n         = 1'b0;
      Row             = 4'hF;
      kp_if.KeyReady  = 1'b0;
      repeat (2) @(posedge Clock);
      #1;
      Reset_n = 1'b1;
   endtask

   logic [63:0] got_mask, exp_mask;

   initial begin
      // ---- table: rotation, press/accept/hold, bounce, two-row priority ----
      for (int t = 0; t < 8; t++)            // ticks 1..8
         add(4'hF, 1'b0, SD, (t % 4 == 0) ? 4'hD : (t % 4 == 1) ? 4'hB : (t % 4 == 2) ? 4'h7 : 4'hE,
             1'b0, 4'h0);
      add(4'hF, 1'b0, SD, 4'hD, 1'b0, 4'h0); // t9
      add(4'hF, 1'b0, SD, 4'hB, 1'b0, 4'h0); // t10: column 2 strobed
      add(4'hB, 1'b0, SD, 4'hB, 1'b0, 4'h0); // t11: row 2 hit, column held
      add(4'hB, 1'b0, SD, 4'hB, 1'b0, 4'h0); // t12
      add(4'hB, 1'b0, SD, 4'hB, 1'b0, 4'h0); // t13
      add(4'hB, 1'b0, SD-1, 4'hB, 1'b0, 4'h0); // one clock before t14
      add(4'hB, 1'b0, 1, 4'hB, 1'b1, 4'hA);  // t14: code {2,2}
      add(4'hB, 1'b1, 1, 4'hB, 1'b0, 4'hA);  // accepted
      add(4'hB, 1'b1, SD-1, 4'hB, 1'b0, 4'hA); // t15: no second code
      add(4'hB, 1'b1, SD, 4'hB, 1'b0, 4'hA); // t16
      add(4'hF, 1'b1, SD, 4'hB, 1'b0, 4'hA); // t17 release 1
      add(4'hF, 1'b1, SD, 4'hB, 1'b0, 4'hA); // t18
      add(4'hF, 1'b1, SD, 4'hB, 1'b0, 4'hA); // t19
      add(4'hF, 1'b1, SD, 4'h7, 1'b0, 4'hA); // t20 release 4: rotate
      add(4'hF, 1'b1, SD, 4'hE, 1'b0, 4'hA); // t21
      add(4'hD, 1'b1, SD, 4'hE, 1'b0, 4'hA); // t22 row 1 bounce
      add(4'hD, 1'b1, SD, 4'hE, 1'b0, 4'hA); // t23
      add(4'hF, 1'b1, SD, 4'hD, 1'b0, 4'hA); // t24 lost: resume rotation
      add(4'hF, 1'b1, SD, 4'hB, 1'b0, 4'hA); // t25
      add(4'hF, 1'b1, SD, 4'h7, 1'b0, 4'hA); // t26
      add(4'hF, 1'b1, SD, 4'hE, 1'b0, 4'hA); // t27
      add(4'h6, 1'b1, SD, 4'hE, 1'b0, 4'hA); // t28 rows 0 and 3 low
      add(4'h6, 1'b1, SD, 4'hE, 1'b0, 4'hA); // t29
      add(4'h6, 1'b1, SD, 4'hE, 1'b0, 4'hA); // t30
      add(4'h6, 1'b1, SD-1, 4'hE, 1'b0, 4'hA);
      add(4'h6, 1'b1, 1, 4'hE, 1'b1, 4'h0);  // t31: row 0 wins
      add(4'h6, 1'b1, 1, 4'hE, 1'b0, 4'h0);

      do_reset();
      chk("reset Col", Col, 4'hE);
      chk("reset KeyValid", kp_if.KeyValid, 1'b0);
      chk("reset KeyCode", kp_if.KeyCode, 4'h0);
      chk("reset Overrun", kp_if.Overrun, 1'b0);

      for (int i = 0; i < tbl.size(); i++) begin
         Row            = tbl[i].row;
         kp_if.KeyReady = tbl[i].rdy;
         adv(tbl[i].cyc);
         chk($sformatf("vec%0d Col", i), Col, tbl[i].col);
         chk($sformatf("vec%0d KeyValid", i), kp_if.KeyValid, tbl[i].kv);
         chk($sformatf("vec%0d KeyCode", i), kp_if.KeyCode, tbl[i].code);
         chk($sformatf("vec%0d Overrun", i), kp_if.Overrun, 1'b0);
      end

      // ---- overrun: key 0 left pending, then key 5 pressed ----
      do_reset();
      Row = 4'hE;
      adv(4*SD - 1);
      chk("ovr key0 early", kp_if.KeyValid, 1'b0);
      adv(1);
      chk("ovr key0 valid", kp_if.KeyValid, 1'b1);
      Row = 4'hF;
      adv(4*SD);                                  // t8: released, column 1
      chk("ovr col after release", Col, 4'hD);
      chk("ovr still pending", kp_if.KeyValid, 1'b1);
      Row = 4'hD;
      adv(4*SD - 1);
      chk("ovr before pulse", kp_if.Overrun, 1'b0);
      adv(1);                                     // t12
      chk("ovr pulse", kp_if.Overrun, 1'b1);
      chk("ovr code kept", kp_if.KeyCode, 4'h0);
      chk("ovr valid kept", kp_if.KeyValid, 1'b1);
      adv(1);
      chk("ovr pulse width", kp_if.Overrun, 1'b0);
      kp_if.KeyReady = 1'b1;
      adv(1);
      chk("ovr accept drops valid", kp_if.KeyValid, 1'b0);
      chk("ovr accept code", kp_if.KeyCode, 4'h0);

      // ---- asynchronous reset mid-DEBOUNCE and mid-HOLD ----
      do_reset();
      adv(SD);                                    // t1: column 1
      Row = 4'hD;
      adv(2*SD);                                  // t3: debouncing on column 1
      chk("dbn col held", Col, 4'hD);
      #2 Reset_n = 1'b0;
      #1;
      chk("rst mid-debounce Col", Col, 4'hE);
      chk("rst mid-debounce KeyValid", kp_if.KeyValid, 1'b0);
      @(posedge Clock);
      #1 Reset_n = 1'b1;
      adv(4*SD);                                  // row 1 on column 0
      chk("hold KeyValid", kp_if.KeyValid, 1'b1);
      chk("hold KeyCode", kp_if.KeyCode, 4'h4);
      #2 Reset_n = 1'b0;
      #1;
      chk("rst mid-hold KeyValid", kp_if.KeyValid, 1'b0);
      chk("rst mid-hold KeyCode", kp_if.KeyCode, 4'h0);
      chk("rst mid-hold Col", Col, 4'hE);
      @(posedge Clock);
      #1 Reset_n = 1'b1;

      // ---- long hold: emission ticks over 60 ticks ----
      do_reset();
      Row            = 4'hE;
      kp_if.KeyReady = 1'b1;
      got_mask       = '0;
      for (int t = 1; t <= 60; t++) begin
         adv(SD);
         if (kp_if.KeyValid) got_mask[t] = 1'b1;
      end
      exp_mask = '0;
      exp_mask[4] = 1'b1;
`ifdef KEYPAD_REPEAT_EN
      exp_mask[36] = 1'b1;
      exp_mask[44] = 1'b1;
      exp_mask[52] = 1'b1;
      exp_mask[60] = 1'b1;
`endif
      chk("held key emit ticks", got_mask, exp_mask);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
